button_debouncer: RTL and testbench

//   Conditions a raw, asynchronous, active-low mechanical push-button input.

---
 rtl/button_debouncer_if.sv | 13 +
 rtl/button_debouncer.sv | 125 ++++++++++++
 tb/tb_button_debouncer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/button_debouncer_if.sv
// Button debouncer signal bundle: raw pin in, debounced level and press strobe out.
// Latency: none (wires only).  Backpressure: none; a level/strobe interface with no handshake.
// Ports: button_raw (pin, active-low), button_clean (debounced, active-low), press_pulse (1-cycle strobe).
interface button_debouncer_if;
   logic button_raw;
   logic button_clean;
   logic press_pulse;

   // master drives the pin and consumes the conditioned outputs
   modport master (output button_raw, input button_clean, input press_pulse);
   // slave is the debouncer itself
   modport slave  (input button_raw, output button_clean, output press_pulse);
endinterface

// File: rtl/button_debouncer.sv
// Debounces an active-low asynchronous push button: 2-flop synchroniser plus per-edge stability counter.
// Latency: a raw step first sampled at edge E changes button_clean at edge E+DEBOUNCE_CYCLES+2.
// Backpressure: none; output is a registered level, press_pulse a one-cycle registered strobe.
// Ports: clk (posedge), rst (synchronous, active-low), btn.slave (button_raw in; button_clean,
//        press_pulse out). Macro BUTTON_DEBOUNCER_PRESS_PULSE_EN enables press_pulse; otherwise it is tied 0.
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_WIDTH       = 20
) (
   input  logic                clk,
   input  logic                rst,
   button_debouncer_if.slave   btn
);

   typedef enum logic [1:0] {
      S_RELEASED     = 2'd0,
      S_WAIT_PRESS   = 2'd1,
      S_PRESSED      = 2'd2,
      S_WAIT_RELEASE = 2'd3
   } state_t;

   // Terminal count: the edge on which the candidate level has been seen DEBOUNCE_CYCLES+1 times in a row.
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic                 sync_q1;
   logic                 sync_q2;
   state_t               state_q;
   state_t               state_d;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic [CNT_WIDTH-1:0] cnt_d;
   logic                 clean_q;
   logic                 clean_d;

   // Synchroniser resets to "released" so a held button is re-qualified after reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q1 <= 1'b1;
         sync_q2 <= 1'b1;
      end else begin
         sync_q1 <= btn.button_raw;
         sync_q2 <= sync_q1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_RELEASED;
         cnt_q   <= '0;
         clean_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         clean_q <= clean_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clean_d = clean_q;
      unique case (state_q)
         S_RELEASED: begin
            if (!sync_q2) begin
               state_d = S_WAIT_PRESS;
               cnt_d   = '0;
            end
         end
         S_WAIT_PRESS: begin
            if (sync_q2) begin
               // bounce: abandon the candidate press, count restarts next time
               state_d = S_RELEASED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_PRESSED;
               clean_d = 1'b0;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_PRESSED: begin
            if (sync_q2) begin
               state_d = S_WAIT_RELEASE;
               cnt_d   = '0;
            end
         end
         S_WAIT_RELEASE: begin
            if (!sync_q2) begin
               state_d = S_PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_RELEASED;
               clean_d = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = S_RELEASED;
            cnt_d   = '0;
         end
      endcase
   end

   assign btn.button_clean = clean_q;

`ifdef BUTTON_DEBOUNCER_PRESS_PULSE_EN
   logic pulse_q;

   // Strobe coincides with the 1->0 step of button_clean; releases never strobe.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pulse_q <= 1'b0;
      end else begin
         pulse_q <= clean_q & ~clean_d;
      end
   end

   assign btn.press_pulse = pulse_q;
`else
   assign btn.press_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer with DEBOUNCE_CYCLES=4, CNT_WIDTH=3: directed vector table,
// hand-written reset corner sequences, then random stimulus against a run-length reference model.
module tb_button_debouncer;

   localparam int DC = 4;
`ifdef BUTTON_DEBOUNCER_PRESS_PULSE_EN
   localparam bit PE = 1'b1;
`else
   localparam bit PE = 1'b0;
`endif

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   button_debouncer_if bus ();

   button_debouncer #(
      .DEBOUNCE_CYCLES (DC),
      .CNT_WIDTH       (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .btn (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit rst;
      bit raw;
      bit exp_clean;
      bit exp_pulse;
      string name;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input bit r, input bit raw, input bit c, input bit p, input string name);
      vec_t v;
      v.rst = r; v.raw = raw; v.exp_clean = c; v.exp_pulse = p & PE; v.name = name;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input bit act, input bit exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b expected %0b at t=%0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive inputs away from the edge, let the edge happen, sample 1 time unit later.
   task automatic step(input bit r, input bit raw, input bit c, input bit p, input string name);
      rst = r;
      bus.button_raw = raw;
      @(posedge clk);
      #1;
      check({name, ".clean"}, bus.button_clean, c);
      check({name, ".pulse"}, bus.press_pulse, p & PE);
   endtask

   // Reference model: button_clean flips once DC+1 consecutive synchronised samples disagree with it.
   bit d1, d2, m_clean, m_pulse;
   int run_len;

   task automatic model_edge(input bit r, input bit raw);
      bit s;
      if (!r) begin
         d1 = 1'b1; d2 = 1'b1; m_clean = 1'b1; m_pulse = 1'b0; run_len = 0;
      end else begin
         s = d2; d2 = d1; d1 = raw;
         m_pulse = 1'b0;
         run_len = (s != m_clean) ? run_len + 1 : 0;
         if (run_len == DC + 1) begin
            m_clean = ~m_clean;
            m_pulse = ~m_clean;
            run_len = 0;
         end
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b0;
      bus.button_raw = 1'b1;
      #2;

      // T1: reset held with the button pressed
      for (int i = 0; i < 3; i++) add(0, 0, 1, 0, "t1_reset");
      for (int i = 0; i < 5; i++) add(1, 1, 1, 0, "t1_idle");
      // T2: clean press, change exactly 6 edges after first low sample
      for (int i = 0; i < 10; i++) add(1, 0, (i < 6), (i == 6), "t2_press");
      // T4: release with one-sample low glitch; count restarts from last 0->1 sample (offset 3)
      for (int i = 0; i < 12; i++) add(1, (i != 2), (i >= 9), 0, "t4_release");
      // T3: 3-edge bounce rejected, then held press qualifies 6 edges after final 1->0 (offset 8)
      for (int i = 0; i < 17; i++) add(1, ((i >= 3) && (i < 8)), (i < 14), (i == 14), "t3_bounce");

      foreach (vecs[i]) step(vecs[i].rst, vecs[i].raw, vecs[i].exp_clean, vecs[i].exp_pulse, vecs[i].name);

      // release before the reset corner cases
      for (int i = 0; i < 10; i++) step(1, 1, (i >= 6), 0, "release");

      // T5: reset in the middle of a press count; qualification restarts from scratch
      for (int i = 0; i < 4; i++) step(1, 0, 1, 0, "t5_count");
      step(0, 0, 1, 0, "t5_rst");
      for (int i = 0; i < 6; i++) step(1, 0, 1, 0, "t5_requal");
      step(1, 0, 0, 1, "t5_press");

      // held button: no repeat strobe; then reset while pressed forces released and re-qualifies
      for (int i = 0; i < 5; i++) step(1, 0, 0, 0, "held");
      step(0, 0, 1, 0, "rst_pressed");
      for (int i = 0; i < 6; i++) step(1, 0, 1, 0, "rst_pressed_wait");
      step(1, 0, 0, 1, "rst_pressed_requal");
      for (int i = 0; i < 15; i++) step(1, 0, 0, 0, "held_long");

      // Random bursts against the reference model, starting from reset
      begin
         bit lvl;
         int remaining;
         bit r;
         model_edge(0, 0);
         step(0, 0, 1, 0, "rnd_reset");
         lvl = 1'b1;
         remaining = 0;
         for (int i = 0; i < 2000; i++) begin
            if (remaining == 0) begin
               lvl = $urandom_range(0, 1);
               remaining = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 14) : $urandom_range(1, 5);
            end
            remaining--;
            r = ($urandom_range(0, 59) != 0);
            model_edge(r, lvl);
            step(r, lvl, m_clean, m_pulse, "rnd");
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
